// File: rtl/ws2812_frame_ctrl.sv
// rtl/ws2812_frame_ctrl.sv - double-buffered WS2812 frame sequencer
//
// Holds two NUM_LEDS x 24-bit GRB pixel banks. The host writes the back bank
// while the front bank is streamed word by word to a 24-bit WS2812 serializer.
// Each frame is followed by a RESET_CYCLES latch gap with the line held low.
// Supports one-shot and continuous refresh.
//
// Optional feature macro: WS2812_BRIGHTNESS_EN (adds a global brightness scaler).
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   wr_en         pixel write strobe into the back bank
//   wr_addr       pixel index (indices >= NUM_LEDS are ignored)
//   wr_data       24-bit pixel word, bit 23 first on the wire
//   frame_start   one-cycle request: swap banks and send a frame
//   continuous    resend the front bank after every latch gap
//   tx_done       serializer pulse: current word finished
//   brightness    (WS2812_BRIGHTNESS_EN only) 8-bit global brightness
//   tx_en         word-stream enable to serializer
//   RGB           word presented to serializer
//   busy          high whenever the sequencer is not idle
//   frame_done    one-cycle pulse at the end of each latch gap

module ws2812_frame_ctrl #(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int RESET_CYCLES = 15000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              frame_start,
  input  logic              continuous,
  input  logic              tx_done,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic              tx_en,
  output logic [23:0]       RGB,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(RESET_CYCLES + 1);

  localparam logic [ADDR_W:0]   N_LEDS   = (ADDR_W+1)'(NUM_LEDS);
  localparam logic [ADDR_W:0]   A_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   A_TWO    = (ADDR_W+1)'(2);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

  state_t            state;
  logic              bank_sel;
  logic              start_pend;
  logic              load_ph;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic [23:0]       rd_data;
  logic [ADDR_W:0]   rd_addr;
  logic [23:0]       rd_word;

  // mem[bank][pixel]; contents are deliberately not reset
  logic [23:0] mem [0:1][0:(1<<ADDR_W)-1];

  // A frame_start in the consuming cycle is merged into the request.
  wire start_req = start_pend | frame_start;

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  function automatic logic [23:0] scale_word(input logic [23:0] w);
    return {scale_ch(w[23:16], brightness), scale_ch(w[15:8], brightness),
            scale_ch(w[7:0], brightness)};
  endfunction
`else
  function automatic logic [23:0] scale_word(input logic [23:0] w);
    return w;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < N_LEDS))
      mem[~bank_sel][wr_addr] <= wr_data;
  end

  // Read address runs one word ahead of RGB so that the next pixel is already
  // in rd_data when tx_done arrives; this is what removes the inter-word bubble.
  always_comb begin
    rd_addr = '0;
    if (state == LOAD)
      rd_addr = load_ph ? A_ONE : '0;
    else if (state == SEND)
      rd_addr = {1'b0, idx} + (tx_done ? A_TWO : A_ONE);
  end

  assign rd_word = (rd_addr < N_LEDS) ? mem[bank_sel][rd_addr[ADDR_W-1:0]] : 24'd0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bank_sel   <= 1'b0;
      start_pend <= 1'b0;
      load_ph    <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      rd_data    <= '0;
      tx_en      <= 1'b0;
      RGB        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_data    <= rd_word;
      if (frame_start)
        start_pend <= 1'b1;

      case (state)
        IDLE: begin
          tx_en <= 1'b0;
          if (start_req) begin
            bank_sel   <= ~bank_sel;
            start_pend <= 1'b0;
            load_ph    <= 1'b0;
            state      <= LOAD;
          end
        end

        LOAD: begin
          if (!load_ph) begin
            load_ph <= 1'b1;
          end else begin
            RGB   <= scale_word(rd_data);
            tx_en <= 1'b1;
            idx   <= '0;
            state <= SEND;
          end
        end

        SEND: begin
          if (tx_done) begin
            if (idx == LAST_IDX) begin
              tx_en <= 1'b0;
              cnt   <= '0;
              state <= LATCH;
            end else begin
              RGB <= scale_word(rd_data);
              idx <= idx + IDX_ONE;
            end
          end
        end

        LATCH: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == LAST_CNT) begin
            frame_done <= 1'b1;
            load_ph    <= 1'b0;
            if (start_req) begin
              bank_sel   <= ~bank_sel;
              start_pend <= 1'b0;
              state      <= LOAD;
            end else if (continuous) begin
              state <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb/tb_ws2812_frame_ctrl.sv - directed self-checking bench for ws2812_frame_ctrl

module tb_ws2812_frame_ctrl;

  localparam int NUM_LEDS = 8;
  localparam int ADDR_W   = 4;
  localparam int RC       = 15000;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              frame_start;
  logic              continuous;
  logic              tx_done;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]        brightness;
`endif
  logic              tx_en;
  logic [23:0]       RGB;
  logic              busy;
  logic              frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  // bench-side model of the two banks and the front-bank selector
  logic [23:0] m [2][8];
  logic        bsel;
  logic [23:0] expf [8];
  logic [23:0] got [8];
  logic        got_en [8];
  int          got_wait;

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(
    .NUM_LEDS    (NUM_LEDS),
    .ADDR_W      (ADDR_W),
    .RESET_CYCLES(RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_start(frame_start),
    .continuous (continuous),
    .tx_done    (tx_done),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .tx_en      (tx_en),
    .RGB        (RGB),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic write_px(input logic [ADDR_W-1:0] a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    if (a < ADDR_W'(NUM_LEDS))
      m[bsel ^ 1'b1][a[2:0]] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic snapshot_front();
    for (int i = 0; i < 8; i++) expf[i] = m[bsel][i];
  endtask

  // Serializer model: holds each word 24 cycles, then pulses tx_done.
  task automatic serve_frame(input int nw);
    got_wait = 0;
    while (tx_en !== 1'b1 && got_wait < 50) begin
      @(negedge clk);
      got_wait++;
    end
    for (int i = 0; i < nw; i++) begin
      got[i]    = RGB;
      got_en[i] = tx_en;
      repeat (23) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic wait_frame_done(input bit spurious, output int cyc);
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < RC + 100) begin
      tx_done = spurious && (cyc % 1000 == 500);
      @(negedge clk);
      cyc++;
    end
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (tx_en !== 1'b0 || RGB !== 24'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: tx_en=%b RGB=%h busy=%b frame_done=%b, expected 0 0 0 0",
               tx_en, RGB, busy, frame_done);
    end
    rst  = 1'b0;
    bsel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int cyc;
    for (int i = 0; i < 8; i++) write_px(ADDR_W'(i), 24'(24'h010203 * i));
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    bsel = ~bsel;
    snapshot_front();
    tests_run++;
    if (busy !== 1'b1 || tx_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_after_e0: busy=%b tx_en=%b, expected 1 0", busy, tx_en);
    end
    serve_frame(8);
    tests_run++;
    if (got_wait !== 2) begin
      tests_failed++;
      $display("FAIL single_tx_en_latency: %0d cycles after E0, expected 2", got_wait);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got[i] !== expf[i] || got_en[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL single_word%0d: RGB=%h tx_en=%b, expected %h 1", i, got[i], got_en[i], expf[i]);
      end
    end
    tests_run++;
    if (tx_en !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_end_of_send: tx_en=%b busy=%b, expected 0 1", tx_en, busy);
    end
    wait_frame_done(1'b1, cyc);
    tests_run++;
    if (cyc !== RC) begin
      tests_failed++;
      $display("FAIL single_latch_gap: frame_done after %0d cycles, expected %0d", cyc, RC);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_busy_after_done: busy=%b, expected 0", busy);
    end
    @(negedge clk);
    tests_run++;
    if (frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done_width: frame_done=%b one cycle later, expected 0", frame_done);
    end
  endtask

  task automatic test_spurious();
    for (int k = 0; k < 3; k++) begin
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      @(negedge clk);
    end
    write_px(ADDR_W'(9), 24'hABCDEF);
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || tx_en !== 1'b0 || RGB !== 24'h070E15) begin
      tests_failed++;
      $display("FAIL spurious_idle: busy=%b tx_en=%b RGB=%h, expected 0 0 070e15", busy, tx_en, RGB);
    end
  endtask

  task automatic test_continuous();
    int cyc;
    for (int i = 0; i < 8; i++) write_px(ADDR_W'(i), 24'(24'hA05000 + i * 17));
    continuous = 1'b1;
    pulse_start();
    bsel = ~bsel;
    snapshot_front();
    for (int f = 0; f < 2; f++) begin
      serve_frame(8);
      if (f == 1) continuous = 1'b0;
      tests_run++;
      if (got_wait !== 2) begin
        tests_failed++;
        $display("FAIL cont_gap%0d: tx_en rose after %0d cycles, expected 2", f, got_wait);
      end
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got[i] !== expf[i] || got_en[i] !== 1'b1) begin
          tests_failed++;
          $display("FAIL cont_f%0d_word%0d: RGB=%h tx_en=%b, expected %h 1", f, i, got[i], got_en[i], expf[i]);
        end
      end
      wait_frame_done(1'b0, cyc);
      tests_run++;
      if (cyc !== RC || busy !== (f == 0)) begin
        tests_failed++;
        $display("FAIL cont_latch%0d: gap=%0d busy=%b, expected %0d %b", f, cyc, busy, RC, f == 0);
      end
    end
  endtask

  task automatic test_midframe_swap();
    int cyc;
    for (int i = 0; i < 8; i++) write_px(ADDR_W'(i), 24'(24'h010203 * i));
    pulse_start();
    bsel = ~bsel;
    snapshot_front();
    fork
      serve_frame(8);
      begin
        repeat (60) @(negedge clk);
        write_px(ADDR_W'(3), 24'hFFFFFF);
        repeat (20) @(negedge clk);
        pulse_start();
      end
    join
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got[i] !== expf[i]) begin
        tests_failed++;
        $display("FAIL mid_old_word%0d: RGB=%h, expected %h", i, got[i], expf[i]);
      end
    end
    wait_frame_done(1'b0, cyc);
    tests_run++;
    if (cyc !== RC || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_latch: gap=%0d busy=%b, expected %0d 1", cyc, busy, RC);
    end
    bsel = ~bsel;
    snapshot_front();
    serve_frame(8);
    tests_run++;
    if (got_wait !== 2 || got[3] !== 24'hFFFFFF) begin
      tests_failed++;
      $display("FAIL mid_new_frame: gap=%0d word3=%h, expected 2 ffffff", got_wait, got[3]);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got[i] !== expf[i]) begin
        tests_failed++;
        $display("FAIL mid_new_word%0d: RGB=%h, expected %h", i, got[i], expf[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    bsel = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_in_latch: busy=%b frame_done=%b, expected 0 0", busy, frame_done);
    end
    pulse_start();
    bsel = ~bsel;
    snapshot_front();
    serve_frame(4);
    repeat (5) @(negedge clk);
    pulse_start();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    bsel = 1'b0;
    tests_run++;
    if (tx_en !== 1'b0 || busy !== 1'b0 || RGB !== 24'd0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_word4: tx_en=%b busy=%b RGB=%h frame_done=%b, expected 0 0 0 0",
               tx_en, busy, RGB, frame_done);
    end
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL rst_pend_dropped: %0d cycles busy or frame_done, expected 0", bad);
    end
    pulse_start();
    bsel = ~bsel;
    snapshot_front();
    serve_frame(8);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got[i] !== expf[i] || got_en[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL rst_refill_word%0d: RGB=%h tx_en=%b, expected %h 1", i, got[i], got_en[i], expf[i]);
      end
    end
    tests_run++;
    if (tx_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_refill_end: tx_en=%b, expected 0", tx_en);
    end
  endtask

`ifdef WS2812_BRIGHTNESS_EN
  task automatic test_brightness();
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    bsel = 1'b0;
    for (int i = 0; i < 8; i++) write_px(ADDR_W'(i), 24'hFF8040);
    brightness = 8'd127;
    pulse_start();
    bsel = ~bsel;
    serve_frame(1);
    tests_run++;
    if (got[0] !== 24'h7F4020) begin
      tests_failed++;
      $display("FAIL brightness_127: RGB=%h, expected 7f4020", got[0]);
    end
    brightness = 8'd255;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    frame_start = 1'b0;
    continuous  = 1'b0;
    tx_done     = 1'b0;
    bsel        = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
    brightness  = 8'd255;
`endif
    test_reset();
    test_single_frame();
    test_spurious();
    test_continuous();
    test_midframe_swap();
    test_reset_midframe();
`ifdef WS2812_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
